// File: rtl/bch_bist.sv
// Built-in self-test sequencer for the bch decoder: replays pattern words through the
// set/ready/finish handshake, checks each result against a golden table and reports.
module bch_bist #(
    parameter int DATA_W  = 64,
    parameter int OUT_W   = 10,
    parameter int PADDR_W = 17,
    parameter int GADDR_W = 14,
    parameter int NTEST_W = 14,
    parameter int ERR_W   = 16,
    parameter int GAP     = 10,
    parameter int TIMEOUT = 100000
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic [NTEST_W-1:0] ntest,
    input  logic               cfg_mode,
    input  logic [1:0]         cfg_code,
    output logic [PADDR_W-1:0] pat_addr,
    input  logic [DATA_W-1:0]  pat_rdata,
    output logic [GADDR_W-1:0] gold_addr,
    input  logic [OUT_W-1:0]   gold_rdata,
    output logic               dut_set,
    output logic               dut_mode,
    output logic [1:0]         dut_code,
    output logic [DATA_W-1:0]  dut_idata,
    input  logic               dut_ready,
    input  logic               dut_finish,
    input  logic [OUT_W-1:0]   dut_odata,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [ERR_W-1:0]   err_cnt,
    output logic [NTEST_W-1:0] test_cnt,
    output logic               ff_valid,
    output logic [NTEST_W-1:0] ff_test,
    output logic [OUT_W-1:0]   ff_got,
    output logic [OUT_W-1:0]   ff_exp,
    output logic [31:0]        cyc_cnt
);
    localparam int WCNT_W = $clog2(TIMEOUT + 2);
    localparam int GCNT_W = $clog2(GAP + 2);
    localparam logic [WCNT_W-1:0] TO_VAL  = WCNT_W'(TIMEOUT);
    localparam logic [GCNT_W-1:0] GAP_VAL = GCNT_W'(GAP);

    typedef enum logic [2:0] {S_IDLE, S_SET, S_WAIT, S_GAP, S_DONE} state_t;

    state_t             state, state_nx;
    logic [WCNT_W-1:0]  wcnt;
    logic [GCNT_W-1:0]  gcnt;
    logic [NTEST_W-1:0] ntest_q;
    logic               active, launch, wait_to, mismatch;

    assign active    = (state == S_SET) || (state == S_WAIT) || (state == S_GAP);
    assign launch    = start && ((state == S_IDLE) || (state == S_DONE));
    assign wait_to   = (state == S_WAIT) && !dut_finish && (wcnt == TO_VAL);
    assign mismatch  = (dut_odata != gold_rdata);
    assign dut_idata = pat_rdata;
    // Status decoded straight from the state register so reset drops them asynchronously.
    assign dut_set   = (state == S_SET);
    assign busy      = active;
    assign done      = (state == S_DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nx;
    end

    // NOTE: state_nx gets a default first so no path through the case infers a latch.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nx = (ntest == '0) ? S_DONE : S_SET;
            S_SET:          state_nx = S_WAIT;
            S_WAIT: begin
                if (dut_finish)   state_nx = S_GAP;
                else if (wait_to) state_nx = S_DONE;
            end
            S_GAP:          if (gcnt == GAP_VAL) state_nx = (test_cnt == ntest_q) ? S_DONE : S_SET;
            default:        state_nx = S_IDLE;
        endcase
    end

    // Timeout counter restarts each time SET is entered; gap counter runs only inside GAP.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wcnt <= '0;
            gcnt <= '0;
        end else begin
            if (state_nx == S_SET)                        wcnt <= '0;
            else if (state == S_SET || state == S_WAIT)   wcnt <= wcnt + WCNT_W'(1);
            gcnt <= (state == S_GAP) ? gcnt + GCNT_W'(1) : '0;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pat_addr  <= '0;
            gold_addr <= '0;
            ntest_q   <= '0;
            dut_mode  <= 1'b0;
            dut_code  <= '0;
            timeout   <= 1'b0;
            err_cnt   <= '0;
            test_cnt  <= '0;
            ff_valid  <= 1'b0;
            ff_test   <= '0;
            ff_got    <= '0;
            ff_exp    <= '0;
            cyc_cnt   <= '0;
        end else if (launch) begin
            pat_addr  <= '0;
            gold_addr <= '0;
            ntest_q   <= ntest;
            dut_mode  <= cfg_mode;
            dut_code  <= cfg_code;
            timeout   <= 1'b0;
            err_cnt   <= '0;
            test_cnt  <= '0;
            ff_valid  <= 1'b0;
            ff_test   <= '0;
            ff_got    <= '0;
            ff_exp    <= '0;
            cyc_cnt   <= '0;
        end else if (active) begin
            if (dut_ready) pat_addr <= pat_addr + PADDR_W'(1);
            if (dut_finish) begin
                gold_addr <= gold_addr + GADDR_W'(1);
                if (mismatch) begin
                    if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
                    if (!ff_valid) begin
                        ff_valid <= 1'b1;
                        ff_test  <= test_cnt;
                        ff_got   <= dut_odata;
                        ff_exp   <= gold_rdata;
                    end
                end
            end
            if (state == S_WAIT && dut_finish) test_cnt <= test_cnt + NTEST_W'(1);
            if (wait_to) timeout <= 1'b1;
            if (cyc_cnt != '1) cyc_cnt <= cyc_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_bch_bist.sv
// Directed bench for bch_bist: a scripted decoder answers set/ready/finish and every
// observable result is compared against hand-derived values.
module tb_bch_bist;
    localparam int DATA_W = 64, OUT_W = 10, PADDR_W = 17, GADDR_W = 14, NTEST_W = 14, ERR_W = 16;

    logic               clk = 1'b0, rstn = 1'b0, start = 1'b0, cfg_mode = 1'b0;
    logic [NTEST_W-1:0] ntest = '0;
    logic [1:0]         cfg_code = '0;
    logic [PADDR_W-1:0] pat_addr;
    logic [DATA_W-1:0]  pat_rdata;
    logic [GADDR_W-1:0] gold_addr;
    logic [OUT_W-1:0]   gold_rdata;
    logic               dut_set, dut_mode, dut_ready = 1'b0, dut_finish = 1'b0;
    logic [1:0]         dut_code;
    logic [DATA_W-1:0]  dut_idata;
    logic [OUT_W-1:0]   dut_odata = '0;
    logic               busy, done, timeout, ff_valid;
    logic [ERR_W-1:0]   err_cnt;
    logic [NTEST_W-1:0] test_cnt, ff_test;
    logic [OUT_W-1:0]   ff_got, ff_exp;
    logic [31:0]        cyc_cnt;

    int nvec = 0, nerr = 0, cyc = 0, set_cyc = 0, done_cyc = 0, s0 = 0, pat_k = 0;

    bch_bist #(.GAP(10), .TIMEOUT(50)) dut (
        .clk(clk), .rstn(rstn), .start(start), .ntest(ntest), .cfg_mode(cfg_mode),
        .cfg_code(cfg_code), .pat_addr(pat_addr), .pat_rdata(pat_rdata),
        .gold_addr(gold_addr), .gold_rdata(gold_rdata), .dut_set(dut_set),
        .dut_mode(dut_mode), .dut_code(dut_code), .dut_idata(dut_idata),
        .dut_ready(dut_ready), .dut_finish(dut_finish), .dut_odata(dut_odata),
        .busy(busy), .done(done), .timeout(timeout), .err_cnt(err_cnt),
        .test_cnt(test_cnt), .ff_valid(ff_valid), .ff_test(ff_test), .ff_got(ff_got),
        .ff_exp(ff_exp), .cyc_cnt(cyc_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] pat_word(input int k);
        return {16'hA5C3, 31'd0, 17'(k)};
    endfunction

    // Golden table; entry 2 is the deliberately "corrupted" value 7.
    function automatic logic [OUT_W-1:0] gold_word(input logic [GADDR_W-1:0] a);
        case (a)
            14'd0:   return 10'h155;
            14'd1:   return 10'h2AA;
            14'd2:   return 10'd7;
            default: return 10'h3C0;
        endcase
    endfunction

    assign pat_rdata  = pat_word(int'(pat_addr));
    assign gold_rdata = gold_word(gold_addr);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input int n, input logic m, input logic [1:0] c);
        @(negedge clk);
        start = 1'b1; ntest = NTEST_W'(n); cfg_mode = m; cfg_code = c;
        @(negedge clk);
        start = 1'b0;
        pat_k = 0;
    endtask

    task automatic wait_set();
        int n = 0;
        while (!dut_set && n < 100) begin @(negedge clk); n++; end
        check("set_seen", dut_set, 1);
        set_cyc = cyc;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 300) begin @(negedge clk); n++; end
        check("done_seen", done, 1);
        done_cyc = cyc;
    endtask

    // Scripted decoder: consume n_ready words, then assert finish for n_fin cycles.
    task automatic serve(input int n_ready, input int n_fin,
                         input logic [OUT_W-1:0] od0, input logic [OUT_W-1:0] od1);
        for (int i = 0; i < n_ready; i++) begin
            check("idata", dut_idata, pat_word(pat_k));
            pat_k++;
            dut_ready = 1'b1;
            @(negedge clk);
        end
        dut_ready = 1'b0;
        for (int j = 0; j < n_fin; j++) begin
            dut_finish = 1'b1;
            dut_odata  = (j == 0) ? od0 : od1;
            @(negedge clk);
        end
        dut_finish = 1'b0;
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_set", dut_set, 0);
        check("rst_pat_addr", pat_addr, 0);
        check("rst_idata", dut_idata, pat_word(0));
        check("rst_err", err_cnt, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Three clean tests: set pulses 5 (latency) + 11 (gap) cycles apart
        do_start(3, 1'b0, 2'd1);
        wait_set(); s0 = set_cyc;
        serve(4, 1, gold_word(0), '0);
        wait_set(); check("spacing01", set_cyc - s0, 16); s0 = set_cyc;
        serve(4, 1, gold_word(1), '0);
        wait_set(); check("spacing12", set_cyc - s0, 16);
        serve(4, 1, gold_word(2), '0);
        wait_done();
        check("t1_test_cnt", test_cnt, 3);
        check("t1_err", err_cnt, 0);
        check("t1_ffv", ff_valid, 0);
        check("t1_busy", busy, 0);
        check("t1_pat_addr", pat_addr, 12);
        check("t1_gold_addr", gold_addr, 3);
        check("t1_code", dut_code, 1);
        check("t1_mode", dut_mode, 0);
        check("t1_cyc_cnt", cyc_cnt, 48);
        check("t1_timeout", timeout, 0);

        // Corrupted golden entry 2: decoder returns 5, table holds 7
        do_start(3, 1'b1, 2'd2);
        wait_set(); serve(2, 1, gold_word(0), '0);
        wait_set(); serve(2, 1, gold_word(1), '0);
        wait_set(); serve(2, 1, 10'd5, '0);
        wait_done();
        check("t2_err", err_cnt, 1);
        check("t2_ffv", ff_valid, 1);
        check("t2_ff_test", ff_test, 2);
        check("t2_ff_got", ff_got, 5);
        check("t2_ff_exp", ff_exp, 7);
        check("t2_mode", dut_mode, 1);
        check("t2_code", dut_code, 2);

        // 17 ready cycles per test, 2 tests; first finish held 2 cycles
        do_start(2, 1'b0, 2'd3);
        wait_set(); serve(17, 2, gold_word(0), gold_word(1));
        wait_set(); serve(17, 1, gold_word(2), '0);
        wait_done();
        check("t3_pat_addr", pat_addr, 34);
        check("t3_gold_addr", gold_addr, 3);
        check("t3_err", err_cnt, 0);
        check("t3_test_cnt", test_cnt, 2);

        // Decoder never finishes: timeout 51 cycles after set
        do_start(2, 1'b0, 2'd1);
        wait_set(); s0 = set_cyc;
        wait_done();
        check("t4_latency", done_cyc - s0, 51);
        check("t4_timeout", timeout, 1);
        check("t4_test_cnt", test_cnt, 0);
        check("t4_busy", busy, 0);
        check("t4_cyc_cnt", cyc_cnt, 51);

        // ntest = 0: straight to DONE
        do_start(0, 1'b0, 2'd1);
        check("t5_done", done, 1);
        check("t5_busy", busy, 0);
        check("t5_set", dut_set, 0);
        check("t5_timeout", timeout, 0);
        check("t5_cyc_cnt", cyc_cnt, 0);

        // start while busy is ignored
        do_start(1, 1'b1, 2'd3);
        wait_set();
        start = 1'b1; ntest = '0;
        @(negedge clk);
        start = 1'b0;
        check("t5b_busy", busy, 1);
        check("t5b_done", done, 0);
        serve(2, 1, gold_word(0), '0);
        wait_done();
        check("t5b_test_cnt", test_cnt, 1);
        check("t5b_code", dut_code, 3);

        // Reset during WAIT of test 1, then rerun from address 0
        do_start(2, 1'b1, 2'd2);
        wait_set(); serve(3, 1, gold_word(0), '0);
        wait_set();
        dut_ready = 1'b1;
        repeat (2) @(negedge clk);
        dut_ready = 1'b0;
        rstn = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_pat_addr", pat_addr, 0);
        check("t6_gold_addr", gold_addr, 0);
        check("t6_test_cnt", test_cnt, 0);
        check("t6_mode", dut_mode, 0);
        check("t6_code", dut_code, 0);
        check("t6_cyc_cnt", cyc_cnt, 0);
        @(negedge clk);
        rstn = 1'b1;
        do_start(1, 1'b0, 2'd1);
        wait_set();
        check("t6_restart_addr", pat_addr, 0);
        serve(2, 1, gold_word(0), '0);
        wait_done();
        check("t6_pat_addr_end", pat_addr, 2);
        check("t6_test_cnt_end", test_cnt, 1);
        check("t6_err_end", err_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/bch_bist.md
# bch_bist

Self-contained built-in self-test sequencer for the `bch` decoder. It replays stored codeword streams into the decoder using the decoder's `set`/`ready`/`finish` protocol and checks every result word against a golden table. It counts mismatches, records the first failure, and aborts a hung test on a per-test timeout. It sits beside `bch` in the silicon test wrapper and generalises the simulation stimulus/check loop into synthesizable, parametrised hardware.

## Interface
Parameters:
- `DATA_W`, 64, width of decoder input word `idata`
- `OUT_W`, 10, width of decoder result `odata`
- `PADDR_W`, 17, pattern memory address width
- `GADDR_W`, 14, golden memory address width
- `NTEST_W`, 14, width of test-count fields
- `ERR_W`, 16, error counter width (saturating)
- `GAP`, 10, idle cycles inserted after each test's first `finish`
- `TIMEOUT`, 100000, maximum cycles from `set` to first `finish`

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock
- `rstn` in 1: asynchronous active-low reset
- `start` in 1: one-cycle pulse; launches a run when not busy
- `ntest` in NTEST_W: number of tests in the run, sampled on `start`
- `cfg_mode` in 1: decoder mode for the run (0 hard, 1 soft), sampled on `start`
- `cfg_code` in 2: code select (1 BCH63, 2 BCH255, 3 BCH1023), sampled on `start`
- `pat_addr` out PADDR_W: pattern memory read address
- `pat_rdata` in DATA_W: pattern word; combinational read of `pat_addr`
- `gold_addr` out GADDR_W: golden memory read address
- `gold_rdata` in OUT_W: golden word; combinational read of `gold_addr`
- `dut_set` out 1: decoder `set`
- `dut_mode` out 1: decoder `mode`
- `dut_code` out 2: decoder `code`
- `dut_idata` out DATA_W: decoder `idata`, equal to `pat_rdata` (pass-through)
- `dut_ready` in 1: decoder `ready`
- `dut_finish` in 1: decoder `finish`
- `dut_odata` in OUT_W: decoder `odata`
- `busy` out 1: run in progress
- `done` out 1: run complete; held until next `start`
- `timeout` out 1: run aborted by timeout
- `err_cnt` out ERR_W: mismatch count
- `test_cnt` out NTEST_W: tests completed
- `ff_valid` out 1: first-fail capture valid
- `ff_test` out NTEST_W: test index of first mismatch
- `ff_got` out OUT_W: `dut_odata` at first mismatch
- `ff_exp` out OUT_W: `gold_rdata` at first mismatch
- `cyc_cnt` out 32: cycles from `start` to `done`, saturating

## Operation
- FSM states: IDLE, SET, WAIT, GAP, DONE.
- IDLE or DONE, on `start`:
  - clear all counters, pointers, flags, and the first-fail capture
  - latch `ntest`, `cfg_mode`, `cfg_code`
  - go to SET, or to DONE if `ntest==0`
- `start` is ignored in SET, WAIT and GAP.
- SET lasts one cycle with `dut_set=1`, then goes to WAIT. The WAIT timeout counter clears on entry to SET.
- WAIT:
  - first cycle with `dut_finish=1`: `test_cnt++`, go to GAP
  - counter reaching TIMEOUT: `timeout=1`, go to DONE
- GAP lasts GAP+1 cycles. Then go to DONE if `test_cnt==ntest`, else to SET.
- Input streaming: in SET, WAIT and GAP, every rising edge with `dut_ready=1` increments `pat_addr`. The pattern pointer is continuous across tests and is not reset between tests.
- Checking: in SET, WAIT and GAP, every edge with `dut_finish=1` performs one check:
  - compare `dut_odata` with `gold_rdata`, then increment `gold_addr`
  - on mismatch, `err_cnt++` (saturating at all-ones)
  - on the first mismatch only, capture `ff_test` (current test index, i.e. `test_cnt` before increment), `ff_got`, `ff_exp`, and set `ff_valid`
  - a `finish` that stays high for several cycles consumes one golden word per cycle
- `dut_ready` and `dut_finish` are ignored in IDLE and DONE.
- `dut_mode`/`dut_code` hold their latched values from `start` until the next `start`.
- Pointer wrap: `pat_addr` and `gold_addr` wrap modulo 2^width silently.

## Timing
- Reset values: every output register is 0, state is IDLE, and `dut_idata` follows `pat_rdata` (address 0).
- `start` sampled at edge t: `busy=1` and `dut_set=1` during cycle t..t+1; WAIT begins at edge t+1.
- The first `finish` seen at edge f moves to GAP; the next `dut_set` pulse comes GAP+1 cycles after f.
- `done=1` and `busy=0` are registered in the same cycle that DONE is entered.
- Reset mid-run: immediate return to IDLE; all counters clear; `dut_set` deasserts asynchronously.

## Test plan
- `ntest=3`, code 1, model decoder that returns golden values: `test_cnt=3`, `err_cnt=0`, `ff_valid=0`, `done=1`, three `dut_set` pulses spaced by decoder latency + GAP+1 cycles.
- Golden entry 2 corrupted (`odata`=5, gold=7): `err_cnt=1`, `ff_test=2` (if one result per test), `ff_got=5`, `ff_exp=7`.
- `ready` asserted 17 cycles per test over 2 tests: `pat_addr=34` at `done`, and the decoder received `pat[0..33]` in order.
- Decoder never asserts `finish`, `TIMEOUT=50`: `timeout=1`, `done=1` exactly 51 cycles after `set`, `test_cnt=0`.
- `ntest=0`: DONE one cycle after `start`, no `dut_set` pulse; a second `start` while busy has no effect.
- `rstn` low during WAIT of test 1: all outputs 0 and IDLE; a following `start` reruns from `pat_addr=0`.
